// File: rtl/uart_wb_initiator_pkg.sv
// Shared constants for the serial-to-Wishbone debug bridge.
// Holds the command/response bytes and the FSM state encodings.
package uart_wb_initiator_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_TO  = 8'h54;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_BUS   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RX_HUNT  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_wb_initiator_rxtx.sv
// 8N1 receiver and transmitter sharing one BAUDDIV setting.
// The transmitter accepts a new byte in the last stop-bit cycle so bytes go out back to back.
module uart_8n1_rxtx
  import uart_wb_initiator_pkg::*;
#(
  parameter int unsigned BAUDDIV = 104
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       tx_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_ferr_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_byte_i,
  output logic       tx_busy_o
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUDDIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUDDIV / 2 - 1);

  logic [1:0]  sync_q;
  logic        rx_prev_q;
  rx_state_e   rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_ferr_q, rx_ferr_d;

  logic        tx_active_q, tx_active_d;
  logic [9:0]  tx_sh_q, tx_sh_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        tx_q, tx_d;
  logic        tx_last;
  logic        rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      rx_st_q     <= RX_HUNT;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_valid_q  <= 1'b0;
      rx_ferr_q   <= 1'b0;
      tx_active_q <= 1'b0;
      tx_sh_q     <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_q        <= 1'b1;
    end else begin
      sync_q      <= {sync_q[0], rx_i};
      rx_prev_q   <= rx_s;
      rx_st_q     <= rx_st_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_valid_q  <= rx_valid_d;
      rx_ferr_q   <= rx_ferr_d;
      tx_active_q <= tx_active_d;
      tx_sh_q     <= tx_sh_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_st_q)
      RX_HUNT: begin
        if (rx_prev_q && !rx_s) begin
          rx_st_d  = RX_START;
          rx_cnt_d = '0;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s ? RX_HUNT : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_valid_d = rx_s;
          rx_ferr_d  = !rx_s;
          rx_st_d    = RX_HUNT;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_st_d = RX_HUNT;
    endcase
  end

  assign tx_last   = tx_active_q && (tx_bit_q == 4'd9) && (tx_cnt_q == BAUD_LAST);
  assign tx_busy_o = tx_active_q && !tx_last;

  always_comb begin
    tx_active_d = tx_active_q;
    tx_sh_d     = tx_sh_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    if (tx_start_i && !tx_busy_o) begin
      tx_active_d = 1'b1;
      tx_sh_d     = {1'b1, tx_byte_i, 1'b0};
      tx_cnt_d    = '0;
      tx_bit_d    = '0;
    end else if (tx_active_q) begin
      if (tx_cnt_q == BAUD_LAST) begin
        tx_cnt_d = '0;
        tx_sh_d  = {1'b1, tx_sh_q[9:1]};
        tx_bit_d = tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) tx_active_d = 1'b0;
      end else begin
        tx_cnt_d = tx_cnt_q + 16'd1;
      end
    end
    tx_d = tx_active_d ? tx_sh_d[0] : 1'b1;
  end

  assign tx_o       = tx_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_byte_o  = rx_sh_q;
  assign rx_ferr_o  = rx_ferr_q;

endmodule

// File: rtl/uart_wb_initiator.sv
// Serial command bridge: 'W'/'R' frames become single Wishbone classic cycles,
// answered with 'K', read data, 'T' on timeout or '?' for unknown commands.
module uart_wb_initiator
  import uart_wb_initiator_pkg::*;
#(
  parameter int unsigned BAUDDIV = 104,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        CLK_I,
  input  logic        RSTN_I,
  input  logic        RX,
  output logic        TX,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  input  logic        ACK_I,
  input  logic [31:0] DAT_I,
  output logic        busy
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  nbyte_q, nbyte_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rsp_q, rsp_d;
  logic [2:0]  rsp_left_q, rsp_left_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic [15:0] to_q, to_d;

  logic        rx_valid, rx_ferr, tx_start, tx_busy;
  logic [7:0]  rx_byte, tx_byte;

  uart_8n1_rxtx #(.BAUDDIV(BAUDDIV)) u_uart (
    .clk_i      (CLK_I),
    .rst_ni     (RSTN_I),
    .rx_i       (RX),
    .tx_o       (TX),
    .rx_valid_o (rx_valid),
    .rx_byte_o  (rx_byte),
    .rx_ferr_o  (rx_ferr),
    .tx_start_i (tx_start),
    .tx_byte_i  (tx_byte),
    .tx_busy_o  (tx_busy)
  );

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      nbyte_q    <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      rsp_q      <= '0;
      rsp_left_q <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      nbyte_q    <= nbyte_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rsp_q      <= rsp_d;
      rsp_left_q <= rsp_left_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      to_q       <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    nbyte_d    = nbyte_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rsp_d      = rsp_q;
    rsp_left_d = rsp_left_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    busy_d     = busy_q;
    to_d       = to_q;
    tx_start   = 1'b0;
    tx_byte    = rsp_q[31:24];
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
            state_d = ST_ADDR;
            is_wr_d = (rx_byte == CMD_WR);
            nbyte_d = '0;
            busy_d  = 1'b1;
          end else begin
            tx_start = 1'b1;
            tx_byte  = RSP_BAD;
          end
        end
      end
      ST_ADDR, ST_WDATA: begin
        if (rx_ferr) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (rx_valid) begin
          if (state_q == ST_ADDR) adr_d = {adr_q[23:0], rx_byte};
          else                    dat_d = {dat_q[23:0], rx_byte};
          nbyte_d = nbyte_q + 2'd1;
          if (nbyte_q == 2'd3) begin
            to_d    = '0;
            state_d = (state_q == ST_ADDR && is_wr_q) ? ST_WDATA : ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // The strobe rises one cycle after entry and is held until ACK or timeout.
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = is_wr_q;
        end else if (ACK_I) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          state_d    = ST_RESP;
          rsp_d      = is_wr_q ? {RSP_OK, 24'h0} : DAT_I;
          rsp_left_d = is_wr_q ? 3'd1 : 3'd4;
        end else if (to_q + 16'd1 == TO_LIMIT) begin
          to_d       = TO_LIMIT;
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          state_d    = ST_RESP;
          rsp_d      = {RSP_TO, 24'h0};
          rsp_left_d = 3'd1;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      ST_RESP: begin
        // tx_busy drops in the final stop-bit cycle, so the next byte or the
        // return to idle lines up exactly with the end of the stop bit.
        if (!tx_busy) begin
          if (rsp_left_q != 3'd0) begin
            tx_start   = 1'b1;
            rsp_d      = {rsp_q[23:0], 8'h00};
            rsp_left_d = rsp_left_q - 3'd1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign CYC_O = cyc_q;
  assign STB_O = cyc_q;
  assign WE_O  = we_q;
  assign SEL_O = {4{cyc_q}};
  assign ADR_O = adr_q;
  assign DAT_O = dat_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_wb_initiator.sv
// Bench for the serial Wishbone bridge: drives 8N1 frames, decodes TX,
// logs bus cycles and compares them with the expected command outcomes.
module tb_uart_wb_initiator;

  localparam int BD = 104;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        tx, cyc, stb, we, ack, busy;
  logic [31:0] adr, dat_o, dat_i;
  logic [3:0]  sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_wb_initiator #(.BAUDDIV(BD), .TIMEOUT(TO)) dut (
    .CLK_I(clk), .RSTN_I(rst_n), .RX(rx), .TX(tx),
    .CYC_O(cyc), .STB_O(stb), .WE_O(we), .ADR_O(adr), .DAT_O(dat_o),
    .SEL_O(sel), .ACK_I(ack), .DAT_I(dat_i), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Responder: ACK after a programmable number of wait states, or never.
  bit          ack_en = 1'b1;
  int          ack_lat = 0;
  int          stb_age = 0;
  logic [31:0] rd_data = 32'h0;
  always @(posedge clk) stb_age <= stb ? stb_age + 1 : 0;
  assign ack   = ack_en && stb && (stb_age >= ack_lat);
  assign dat_i = rd_data;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    int          len;
  } bus_rec_t;
  bus_rec_t bus_q[$];

  initial begin
    bus_rec_t cur;
    logic stb_prev;
    stb_prev = 1'b0;
    cur = '{32'h0, 32'h0, 1'b0, 4'h0, 0};
    forever begin
      @(negedge clk);
      if (stb && !stb_prev) cur = '{adr, dat_o, we, sel, 1};
      else if (stb) cur.len++;
      else if (stb_prev) bus_q.push_back(cur);
      stb_prev = stb;
    end
  end

  // TX decoder: records each byte and the cycle its start bit was seen.
  int         cyc_n = 0;
  logic [7:0] txq[$];
  int         txst[$];
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    logic       tx_prev;
    logic [7:0] b;
    int         st;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_prev && !tx) begin
        st = cyc_n;
        repeat (BD / 2) @(negedge clk);
        if (!tx) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BD) @(negedge clk);
            b[i] = tx;
          end
          repeat (BD) @(negedge clk);
          if (tx) begin
            txq.push_back(b);
            txst.push_back(st);
          end else begin
            txq.push_back(8'hxx);
            txst.push_back(st);
          end
        end
      end
      tx_prev = tx;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_len);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int left;
    left = budget;
    while (txq.size() < n && left > 0) begin
      @(negedge clk);
      left--;
    end
  endtask

  // Model: the expected bus cycle and response follow directly from the command.
  task automatic do_cmd(input string tag, input bit is_wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rdv,
                        input int lat, input bit en);
    logic [7:0] exp_rsp[$];
    int         exp_len;
    ack_en  = en;
    ack_lat = lat;
    rd_data = rdv;
    bus_q.delete();
    txq.delete();
    txst.delete();
    send_byte(is_wr ? 8'h57 : 8'h52, 1'b1, BD);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1, BD);
    if (is_wr) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1, BD);
    if (!en) exp_rsp = '{8'h54};
    else if (is_wr) exp_rsp = '{8'h4B};
    else exp_rsp = '{rdv[31:24], rdv[23:16], rdv[15:8], rdv[7:0]};
    exp_len = en ? lat + 1 : TO;
    wait_tx(exp_rsp.size(), (exp_rsp.size() + 2) * 10 * BD + TO + 200);
    check({tag, ".nrsp"}, txq.size(), exp_rsp.size());
    check({tag, ".busy_hi"}, busy, 1'b1);
    foreach (exp_rsp[i]) if (i < txq.size()) check({tag, ".rsp"}, txq[i], exp_rsp[i]);
    check({tag, ".nbus"}, bus_q.size(), 1);
    if (bus_q.size() > 0) begin
      check({tag, ".adr"}, bus_q[0].adr, a);
      check({tag, ".we"}, bus_q[0].we, is_wr);
      check({tag, ".sel"}, bus_q[0].sel, 4'hF);
      check({tag, ".stblen"}, bus_q[0].len, exp_len);
      if (is_wr) check({tag, ".dat"}, bus_q[0].dat, d);
    end
    repeat (BD / 2 + 4) @(negedge clk);
    check({tag, ".busy_lo"}, busy, 1'b0);
    check({tag, ".tx_idle"}, tx, 1'b1);
    $display("txn %s %s adr=%h wdat=%h rdat=%h lat=%0d ack=%0d rsp_bytes=%0d",
             tag, is_wr ? "W" : "R", a, d, rdv, lat, en, txq.size());
  endtask

  initial begin
    bit          rw;
    logic [31:0] ra, rd;
    int          wait_left;

    repeat (3) @(negedge clk);
    check("rst.tx", tx, 1'b1);
    check("rst.cyc", cyc, 1'b0);
    check("rst.stb", stb, 1'b0);
    check("rst.we", we, 1'b0);
    check("rst.adr", adr, 32'h0);
    check("rst.dat", dat_o, 32'h0);
    check("rst.sel", sel, 4'h0);
    check("rst.busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    do_cmd("wr_led", 1'b1, 32'h6000_0004, 32'h0000_0005, 32'h0, 0, 1'b1);

    do_cmd("rd_wait", 1'b0, 32'h6000_0008, 32'h0, 32'h0000_0100, 3, 1'b1);
    check("rd_wait.byte_period", (txst.size() > 1) ? txst[1] - txst[0] : 0, 10 * BD);

    do_cmd("timeout", 1'b0, 32'h1234_5678, 32'h0, 32'h0, 0, 1'b0);

    txq.delete();
    send_byte(8'h41, 1'b1, BD);
    wait_tx(1, 3 * 10 * BD);
    check("bad.nrsp", txq.size(), 1);
    if (txq.size() > 0) check("bad.rsp", txq[0], 8'h3F);
    check("bad.busy", busy, 1'b0);
    $display("txn bad_cmd byte=41 rsp_bytes=%0d", txq.size());
    repeat (BD) @(negedge clk);

    bus_q.delete();
    txq.delete();
    send_byte(8'h57, 1'b1, BD);
    check("ferr.busy_cmd", busy, 1'b1);
    send_byte(8'h60, 1'b1, BD);
    send_byte(8'hA5, 1'b0, BD);
    repeat (3 * BD) @(negedge clk);
    check("ferr.nbus", bus_q.size(), 0);
    check("ferr.nrsp", txq.size(), 0);
    check("ferr.busy", busy, 1'b0);
    $display("txn framing_error after 57 60 bus=%0d rsp=%0d", bus_q.size(), txq.size());

    do_cmd("wr_rand", 1'b1, $urandom, $urandom, 32'h0, $urandom_range(0, 4), 1'b1);

    txq.delete();
    bus_q.delete();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (12 * BD) @(negedge clk);
    check("glitch.nrsp", txq.size(), 0);
    check("glitch.busy", busy, 1'b0);
    check("glitch.nbus", bus_q.size(), 0);
    $display("txn rx_glitch 10 cycles rsp=%0d", txq.size());

    ack_en = 1'b0;
    send_byte(8'h52, 1'b1, BD);
    for (int i = 3; i >= 0; i--) send_byte(8'h40 + 8'(i), 1'b1, (i == 0) ? 0 : BD);
    wait_left = 3 * BD;
    while (!stb && wait_left > 0) begin
      @(negedge clk);
      wait_left--;
    end
    check("arst.stb_seen", stb, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.cyc", cyc, 1'b0);
    check("arst.stb", stb, 1'b0);
    check("arst.busy", busy, 1'b0);
    check("arst.tx", tx, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("arst.adr", adr, 32'h0);
    $display("txn async_reset during strobe");
    repeat (5) @(negedge clk);

    do_cmd("rd_rand", 1'b0, $urandom, 32'h0, $urandom, $urandom_range(0, 4), 1'b1);

    rw = 1'($urandom_range(0, 1));
    ra = $urandom;
    rd = $urandom;
    do_cmd("any_rand", rw, ra, rd, ~rd, $urandom_range(0, 4), 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
